// File: rtl/debug_probe_display.sv
// debug_probe_display: picks one of NUM_CH probe channels for the six-digit hex
// display. The channel can be shown live, from its capture register, auto-cycled or frozen.
// Optional feature macro: HEXDBG_CAPTURE_EN (shadow registers, edge detect, captured flags).
// Ports: Clk, Reset (sync, active-high), probe_data, capture_strobe, clear, sel, mode,
//        hex_digits (registered nibbles), cur_ch (displayed channel), captured (sticky flags).
module debug_probe_display #(
  parameter int         NUM_CH      = 8,
  parameter int         DIGITS      = 6,
  parameter int         CYCLE_TICKS = 50_000_000,
  parameter logic [3:0] FILL_NIBBLE = 4'h1,
  parameter int         SEL_W       = $clog2(NUM_CH)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NUM_CH*DIGITS*4-1:0]   probe_data,
  input  logic [NUM_CH-1:0]            capture_strobe,
  input  logic                         clear,
  input  logic [SEL_W-1:0]             sel,
  input  logic [1:0]                   mode,
  output logic [DIGITS*4-1:0]          hex_digits,
  output logic [SEL_W-1:0]             cur_ch,
  output logic [NUM_CH-1:0]            captured
);

  localparam int DW = DIGITS * 4;
  localparam int CW = $clog2(CYCLE_TICKS + 1);

  localparam logic [CW-1:0]    TERM    = CW'(CYCLE_TICKS - 1);
  localparam logic [CW-1:0]    TICK1   = CW'(1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] CH1     = SEL_W'(1);
  localparam logic [SEL_W:0]   NCH     = (SEL_W + 1)'(NUM_CH);
  localparam logic [DW-1:0]    FILL    = {DIGITS{FILL_NIBBLE}};

  typedef enum logic [1:0] {
    M_LIVE = 2'b00,
    M_CAPT = 2'b01,
    M_AUTO = 2'b10,
    M_FRZ  = 2'b11
  } mode_e;

  mode_e            mode_d;
  mode_e            mode_q;
  logic [CW-1:0]    tick;
  logic             tick_end;
  logic             auto_entry;
  logic [SEL_W-1:0] next_ch;
  logic [DW-1:0]    live_sel;
  logic [DW-1:0]    src;

  assign mode_d     = mode_e'(mode);
  assign auto_entry = (mode_d == M_AUTO) && (mode_q != M_AUTO);
  assign tick_end   = (tick == TERM);

  // Channel to be shown after this edge.
  always_comb begin
    next_ch = cur_ch;
    unique case (mode_d)
      M_LIVE, M_CAPT: next_ch = sel;
      M_AUTO: begin
        if (auto_entry)
          next_ch = ({1'b0, sel} < NCH) ? sel : '0;
        else if (tick_end)
          next_ch = (cur_ch >= LAST_CH) ? '0 : cur_ch + CH1;
      end
      M_FRZ: next_ch = cur_ch;
    endcase
  end

  // Unmatched selects keep the fill pattern.
  always_comb begin
    live_sel = FILL;
    for (int i = 0; i < NUM_CH; i++) begin
      if (next_ch == SEL_W'(i))
        live_sel = probe_data[i*DW +: DW];
    end
  end

`ifdef HEXDBG_CAPTURE_EN
  logic [NUM_CH-1:0] strobe_q;
  logic [NUM_CH-1:0] rise;
  logic [DW-1:0]     shadow [NUM_CH];
  logic [DW-1:0]     cap_sel;

  assign rise = capture_strobe & ~strobe_q;

  always_comb begin
    cap_sel = FILL;
    for (int i = 0; i < NUM_CH; i++) begin
      if (next_ch == SEL_W'(i))
        cap_sel = shadow[i];
    end
  end

  assign src = (mode_d == M_CAPT) ? cap_sel : live_sel;

  // A rise in the same cycle as clear still leaves its flag set.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      strobe_q <= '0;
      captured <= '0;
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= '0;
    end else begin
      strobe_q <= capture_strobe;
      captured <= (clear ? '0 : captured) | rise;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i])
          shadow[i] <= probe_data[i*DW +: DW];
      end
    end
  end
`else
  logic unused_cap;

  assign unused_cap = ^{capture_strobe, clear};
  assign src        = live_sel;
  assign captured   = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q     <= M_LIVE;
      tick       <= '0;
      cur_ch     <= '0;
      hex_digits <= '0;
    end else begin
      mode_q <= mode_d;
      // Entry restarts the count so the first channel gets a full period.
      if (mode_d != M_AUTO || auto_entry || tick_end)
        tick <= '0;
      else
        tick <= tick + TICK1;
      if (mode_d != M_FRZ) begin
        cur_ch     <= next_ch;
        hex_digits <= src;
      end
    end
  end

endmodule
